rotary_ring_ctrl: RTL
=====================

Name: rotary_ring_ctrl

Overview:
Upstream stage of the LED ring driver: turns raw rotary-encoder quadrature inputs and the push-button into ring frame requests. Synchronises and debounces the encoder signals, keeps a wrapping position 0..NUM_LEDS-1 and a colour selection, and builds led_mask/colour/intensity. Issues a one-cycle refresh to the driver whenever the displayed state changes and the driver is idle.

Parameters:
DEBOUNCE_CYCLES, 4000, consecutive stable cycles needed before a debounced input changes (100 us at 40 MHz); counter width is $clog2(DEBOUNCE_CYCLES+1).
NUM_LEDS, 12, ring size; must equal led_mask width.
DEFAULT_INTENSITY, 8'h20, constant driven on intensity.

Ports:
clock  input  1  system clock, 40 MHz
res_n  input  1  reset, asynchronous, active-low
enc_a  input  1  encoder channel A, asynchronous, raw
enc_b  input  1  encoder channel B, asynchronous, raw
enc_btn  input  1  encoder push-button, asynchronous, active-low, raw
driver_busy  input  1  high while the LED driver is transmitting
led_mask  output  12  one bit per LED, to driver
colour  output  2  GRB mask, to driver
intensity  output  8  to driver, always DEFAULT_INTENSITY
refresh  output  1  one-cycle frame request
position  output  4  current internal position, for debug

Behaviour:
- Reset (async, res_n=0): position=0, internal colour=2'b01, led_mask=12'h001, colour=2'b01, intensity=DEFAULT_INTENSITY, refresh=0, FSM=IDLE, dirty=1 so exactly one frame goes out after reset. Debounced A/B/btn reset to 0/0/1. Asserting reset mid-frame drops refresh immediately; no partial state is kept.
- Sync: 2-FF synchroniser per raw input, reset to the debounced reset values.
- Debounce: per-input counter. It clears whenever the synced value equals the debounced value. Otherwise it increments, and the debounced value takes the synced value when the count reaches DEBOUNCE_CYCLES-1. Glitches shorter than DEBOUNCE_CYCLES cycles never propagate.
- Decode: act on debounced A rising edge only (one step per detent).
  - B=0 gives CW: position+1, with NUM_LEDS-1 wrapping to 0.
  - B=1 gives CCW: position-1, with 0 wrapping to NUM_LEDS-1.
  - A falling edges and B edges cause no step.
- Button: debounced btn falling edge advances colour 01->10->11->01. Releasing the button does nothing.
- Step and button edge in the same cycle: both are applied and a single dirty flag is set.
- Internal position/colour update the cycle after the debounced edge (cycle E+1), and dirty is set in that same cycle.
- Refresh FSM:
  - IDLE: if dirty and !driver_busy, load output registers (led_mask from position, colour) and clear dirty, then go to REQ. Outputs change only in this transition, so they are stable for the whole transmission.
  - REQ: refresh=1 for exactly one cycle, then go to GUARD.
  - GUARD: 2 cycles in which driver_busy is ignored, giving the driver time to raise it. Then go to WAIT.
  - WAIT: stay until driver_busy=0, then go to IDLE.
  - Events arriving in REQ/GUARD/WAIT only set dirty. Any number of events coalesce into one follow-up frame carrying the latest state.
- Latency with FSM in IDLE and busy low: edge at E gives outputs updated at E+2 and refresh high at E+3.
- led_mask (default build): one-hot, bit[position]=1.

Optional Feature:
BAR_MODE_EN: when defined, led_mask is a thermometer code with bits [position:0] set (position 0 gives 12'h001, position 11 gives 12'hFFF). When undefined, led_mask is one-hot. Nothing else changes.

Test Plan:
- Reset, busy=0, DEBOUNCE_CYCLES=8 -> exactly one refresh pulse within 4 cycles of release; led_mask=12'h001, colour=01, intensity=8'h20.
- Three CW detents (A rises with B=0), each held 20 cycles -> position 1,2,3; three refresh pulses; final led_mask=12'h008 (12'h00F with BAR_MODE_EN).
- At position 0, one CCW detent -> position=11, led_mask=12'h800; then one CW detent -> position=0, led_mask=12'h001.
- A glitch of 5 cycles at DEBOUNCE_CYCLES=8 -> no position change and no refresh.
- driver_busy held high for 100 cycles while 2 CW steps and 1 button press occur -> no refresh during busy; exactly one refresh after busy falls, with position=2 and colour=10.
- Button pressed 3 times -> colour sequence 10,11,01; res_n pulsed low during GUARD -> refresh=0 at once, outputs return to reset values, one post-reset frame follows.

Source files
------------

// File: rtl/rotary_ring_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rotary_ring_ctrl
//  Purpose  : Rotary encoder / push-button front end for the LED ring driver.
//             Synchronises and debounces the raw inputs, tracks ring position
//             and colour, and issues one-cycle frame requests to the driver.
//             Optional macro BAR_MODE_EN selects a thermometer led_mask.
//  Revision : 1.0 - initial release
// ============================================================================
module rotary_ring_ctrl #(
    parameter int         DEBOUNCE_CYCLES   = 4000,
    parameter int         NUM_LEDS          = 12,
    parameter logic [7:0] DEFAULT_INTENSITY = 8'h20
) (
    input  logic                clock,
    input  logic                res_n,
    input  logic                enc_a,
    input  logic                enc_b,
    input  logic                enc_btn,
    input  logic                driver_busy,
    output logic [NUM_LEDS-1:0] led_mask,
    output logic [1:0]          colour,
    output logic [7:0]          intensity,
    output logic                refresh,
    output logic [3:0]          position
);

    localparam int          c_cnt_w   = $clog2(DEBOUNCE_CYCLES + 1);
    // Bit order {btn, b, a}; the button idles high (active-low).
    localparam logic [2:0]  c_deb_rst = 3'b100;
    localparam logic [3:0]  c_pos_max = 4'(NUM_LEDS - 1);
    localparam logic [1:0]  c_col_rst = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_GUARD = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    logic [2:0]          w_raw;
    logic [2:0]          r_sync1;
    logic [2:0]          r_sync2;
    logic [2:0]          w_deb;
    logic                r_a_q;
    logic                r_btn_q;
    logic                w_a_rise;
    logic                w_btn_fall;
    logic [3:0]          r_pos;
    logic [1:0]          r_col;
    logic                r_dirty;
    logic [NUM_LEDS-1:0] w_mask;
    logic [NUM_LEDS-1:0] r_led_mask;
    logic [1:0]          r_colour;
    logic                r_refresh;
    logic                r_guard_cnt;
    state_t              r_state;
    state_t              w_next;
    logic                w_load;

    assign w_raw = {enc_btn, enc_b, enc_a};

    always_ff @(posedge clock or negedge res_n) begin
        if (!res_n) begin
            r_sync1 <= c_deb_rst;
            r_sync2 <= c_deb_rst;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar g = 0; g < 3; g++) begin : g_deb
            logic [c_cnt_w-1:0] r_cnt;
            logic               r_deb_bit;

            always_ff @(posedge clock or negedge res_n) begin
                if (!res_n) begin
                    r_cnt     <= '0;
                    r_deb_bit <= c_deb_rst[g];
                end else if (r_sync2[g] == r_deb_bit) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_cnt_w'(DEBOUNCE_CYCLES - 1)) begin
                    r_deb_bit <= r_sync2[g];
                    r_cnt     <= '0;
                end else begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end

            assign w_deb[g] = r_deb_bit;
        end
    endgenerate

    always_ff @(posedge clock or negedge res_n) begin
        if (!res_n) begin
            r_a_q   <= c_deb_rst[0];
            r_btn_q <= c_deb_rst[2];
        end else begin
            r_a_q   <= w_deb[0];
            r_btn_q <= w_deb[2];
        end
    end

    // One step per detent: only the debounced A rising edge counts.
    assign w_a_rise   = w_deb[0] & ~r_a_q;
    assign w_btn_fall = ~w_deb[2] & r_btn_q;

    always_ff @(posedge clock or negedge res_n) begin
        if (!res_n) begin
            r_pos   <= 4'd0;
            r_col   <= c_col_rst;
            r_dirty <= 1'b1;
        end else begin
            if (w_a_rise) begin
                if (w_deb[1]) begin
                    r_pos <= (r_pos == 4'd0) ? c_pos_max : r_pos - 4'd1;
                end else begin
                    r_pos <= (r_pos == c_pos_max) ? 4'd0 : r_pos + 4'd1;
                end
            end
            if (w_btn_fall) begin
                r_col <= (r_col == 2'b11) ? 2'b01 : r_col + 2'b01;
            end
            // A new event wins over a load in the same cycle, since the load
            // captured the pre-event state.
            if (w_a_rise || w_btn_fall) begin
                r_dirty <= 1'b1;
            end else if (w_load) begin
                r_dirty <= 1'b0;
            end
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
`ifdef BAR_MODE_EN
            w_mask[i] = (4'(i) <= r_pos);
`else
            w_mask[i] = (4'(i) == r_pos);
`endif
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_dirty && !driver_busy) begin
                    w_load = 1'b1;
                    w_next = ST_REQ;
                end
            end
            ST_REQ:   w_next = ST_GUARD;
            ST_GUARD: begin
                if (r_guard_cnt) begin
                    w_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!driver_busy) begin
                    w_next = ST_IDLE;
                end
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    // Outputs are only reloaded on IDLE->REQ so they hold for a whole frame.
    always_ff @(posedge clock or negedge res_n) begin
        if (!res_n) begin
            r_state     <= ST_IDLE;
            r_guard_cnt <= 1'b0;
            r_refresh   <= 1'b0;
            r_led_mask  <= NUM_LEDS'(1);
            r_colour    <= c_col_rst;
        end else begin
            r_state     <= w_next;
            r_guard_cnt <= (r_state == ST_GUARD) ? ~r_guard_cnt : 1'b0;
            r_refresh   <= (r_state == ST_REQ);
            if (w_load) begin
                r_led_mask <= w_mask;
                r_colour   <= r_col;
            end
        end
    end

    assign led_mask  = r_led_mask;
    assign colour    = r_colour;
    assign intensity = DEFAULT_INTENSITY;
    assign refresh   = r_refresh;
    assign position  = r_pos;

endmodule
`default_nettype wire
